exec_datapath: RTL and testbench

EXEC_DATAPATH -- requirements
Module: exec_datapath

---
 rtl/exec_datapath.sv | 138 +++++++++++++
 tb/tb_exec_datapath.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/exec_datapath.sv
// EX/DM/WB execute datapath: forwarding muxes, 16-bit ALU with Z/C flags,
// 32x16 register file, 256x16 data memory and the three result pipeline registers.
module exec_datapath (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op_dec,
  input  logic [4:0]  rs_a,
  input  logic [4:0]  rs_b,
  input  logic [15:0] imm,
  input  logic        imm_sel,
  input  logic [1:0]  mux_sel_A,
  input  logic [1:0]  mux_sel_B,
  input  logic        mem_en_ex,
  input  logic        mem_rw_ex,
  input  logic        mem_mux_sel_dm,
  input  logic [4:0]  RW_dm,
  output logic [15:0] ans_ex,
  output logic [15:0] ans_dm,
  output logic [15:0] ans_wb,
  output logic        flag_z,
  output logic        flag_c
);

  logic [15:0] rf_q [32];
  logic [15:0] rf_d [32];
  logic [15:0] mem_q [256];

  logic [15:0] ans_ex_q, ans_ex_d;
  logic [15:0] ans_dm_q, ans_dm_d;
  logic [15:0] ans_wb_q, ans_wb_d;
  logic [15:0] ld_q, ld_d;
  logic        flag_z_q, flag_z_d;
  logic        flag_c_q, flag_c_d;

  logic [15:0] rf_a, rf_b;
  logic [15:0] fwd_b;
  logic [15:0] op_a, op_b;
  logic [15:0] alu_res;
  logic [16:0] sum17;
  logic        unused_op_bit;

  // Bit 3 of the opcode does not select an ALU operation.
  assign unused_op_bit = op_dec[3];

  assign rf_a = rf_q[rs_a];
  assign rf_b = rf_q[rs_b];

  always_comb begin
    op_a  = rf_a;
    fwd_b = rf_b;
    case (mux_sel_A)
      2'b00:   op_a = rf_a;
      2'b01:   op_a = ans_ex_q;
      2'b10:   op_a = ans_dm_q;
      default: op_a = ans_wb_q;
    endcase
    case (mux_sel_B)
      2'b00:   fwd_b = rf_b;
      2'b01:   fwd_b = ans_ex_q;
      2'b10:   fwd_b = ans_dm_q;
      default: fwd_b = ans_wb_q;
    endcase
    op_b = imm_sel ? imm : fwd_b;
  end

  // Carry only changes on ADD/SUB; every non-ALU opcode passes operand A through.
  always_comb begin
    alu_res  = op_a;
    flag_c_d = flag_c_q;
    sum17    = '0;
    if (op_dec[5:4] == 2'b00) begin
      case (op_dec[2:0])
        3'b000: begin
          sum17    = {1'b0, op_a} + {1'b0, op_b};
          alu_res  = sum17[15:0];
          flag_c_d = sum17[16];
        end
        3'b001: begin
          alu_res  = op_a - op_b;
          flag_c_d = (op_a < op_b);
        end
        3'b010:  alu_res = op_a & op_b;
        3'b011:  alu_res = op_a | op_b;
        3'b100:  alu_res = op_a ^ op_b;
        3'b101:  alu_res = ~op_a;
        3'b110:  alu_res = {op_a[14:0], 1'b0};
        default: alu_res = {1'b0, op_a[15:1]};
      endcase
    end
  end

  always_comb begin
    ans_ex_d = alu_res;
    flag_z_d = (alu_res == 16'h0000);
    ld_d     = ld_q;
    if (mem_en_ex && !mem_rw_ex) ld_d = mem_q[op_a[7:0]];
    ans_dm_d = mem_mux_sel_dm ? ld_q : ans_ex_q;
    ans_wb_d = ans_dm_q;
  end

  // Register 0 is never written, so it keeps its reset value of zero.
  always_comb begin
    rf_d = rf_q;
    if (RW_dm != 5'd0) rf_d[RW_dm] = ans_dm_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ans_ex_q <= '0;
      ans_dm_q <= '0;
      ans_wb_q <= '0;
      ld_q     <= '0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      ans_ex_q <= ans_ex_d;
      ans_dm_q <= ans_dm_d;
      ans_wb_q <= ans_wb_d;
      ld_q     <= ld_d;
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
      rf_q     <= rf_d;
    end
  end

  // Memory contents survive reset; stores are simply suppressed while it is held.
  always_ff @(posedge clk) begin
    if (reset && mem_en_ex && mem_rw_ex) mem_q[op_a[7:0]] <= op_b;
  end

  assign ans_ex = ans_ex_q;
  assign ans_dm = ans_dm_q;
  assign ans_wb = ans_wb_q;
  assign flag_z = flag_z_q;
  assign flag_c = flag_c_q;

endmodule

// File: tb/tb_exec_datapath.sv
// Directed bench for exec_datapath: one instruction per cycle, outputs sampled
// 1 time unit after each rising edge against hand-computed values.
module tb_exec_datapath;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_AND  = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b000011;
  localparam logic [5:0] OP_XOR  = 6'b000100;
  localparam logic [5:0] OP_NOT  = 6'b000101;
  localparam logic [5:0] OP_SHL  = 6'b000110;
  localparam logic [5:0] OP_SHR  = 6'b000111;
  localparam logic [5:0] OP_ADD8 = 6'b001000;
  localparam logic [5:0] OP_PASS = 6'b010000;
  localparam logic [5:0] OP_LD   = 6'b010100;
  localparam logic [5:0] OP_ST   = 6'b010101;
  localparam logic [5:0] OP_MISC = 6'b100111;

  logic        clk;
  logic        reset;
  logic [5:0]  op_dec;
  logic [4:0]  rs_a, rs_b;
  logic [15:0] imm;
  logic        imm_sel;
  logic [1:0]  mux_sel_A, mux_sel_B;
  logic        mem_en_ex, mem_rw_ex, mem_mux_sel_dm;
  logic [4:0]  RW_dm;
  logic [15:0] ans_ex, ans_dm, ans_wb;
  logic        flag_z, flag_c;

  int total = 0;
  int bad   = 0;

  exec_datapath dut (
    .clk            (clk),
    .reset          (reset),
    .op_dec         (op_dec),
    .rs_a           (rs_a),
    .rs_b           (rs_b),
    .imm            (imm),
    .imm_sel        (imm_sel),
    .mux_sel_A      (mux_sel_A),
    .mux_sel_B      (mux_sel_B),
    .mem_en_ex      (mem_en_ex),
    .mem_rw_ex      (mem_rw_ex),
    .mem_mux_sel_dm (mem_mux_sel_dm),
    .RW_dm          (RW_dm),
    .ans_ex         (ans_ex),
    .ans_dm         (ans_dm),
    .ans_wb         (ans_wb),
    .flag_z         (flag_z),
    .flag_c         (flag_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one EX-stage instruction plus the DM-stage controls of that cycle, then clocks it.
  task automatic apply_stimulus(input logic [5:0] op, input logic [4:0] ra, input logic [4:0] rb,
                                input logic [15:0] im, input logic isel,
                                input logic [1:0] sa, input logic [1:0] sb,
                                input logic men, input logic mrw, input logic mms,
                                input logic [4:0] rw);
    op_dec = op; rs_a = ra; rs_b = rb; imm = im; imm_sel = isel;
    mux_sel_A = sa; mux_sel_B = sb;
    mem_en_ex = men; mem_rw_ex = mrw; mem_mux_sel_dm = mms; RW_dm = rw;
    @(posedge clk);
    #1;
  endtask

  task automatic nop(input logic mms, input logic [4:0] rw);
    apply_stimulus(OP_PASS, 5'd0, 5'd0, 16'h0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, mms, rw);
  endtask

  initial begin
    reset = 1'b0;
    op_dec = OP_PASS; rs_a = '0; rs_b = '0; imm = '0; imm_sel = 1'b0;
    mux_sel_A = '0; mux_sel_B = '0;
    mem_en_ex = 1'b0; mem_rw_ex = 1'b0; mem_mux_sel_dm = 1'b0; RW_dm = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_output("rst_ans_ex", ans_ex, 16'h0);
    check_output("rst_ans_dm", ans_dm, 16'h0);
    check_output("rst_ans_wb", ans_wb, 16'h0);
    check_output("rst_flags", {14'd0, flag_z, flag_c}, 16'h0);
    reset = 1'b1;

    // Seed R1=5, R2=7 through the pipeline.
    apply_stimulus(OP_ADD, 5'd0, 5'd0, 16'd5, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
    check_output("seed_first_edge", ans_ex, 16'd5);
    apply_stimulus(OP_ADD, 5'd0, 5'd0, 16'd7, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
    nop(1'b0, 5'd1);
    nop(1'b0, 5'd2);

    // Back-to-back dependency via ans_ex forwarding.
    apply_stimulus(OP_ADD, 5'd1, 5'd2, 16'h0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
    check_output("fwd_add1", ans_ex, 16'd12);
    apply_stimulus(OP_ADD, 5'd0, 5'd1, 16'h0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
    check_output("fwd_add2", ans_ex, 16'd17);
    check_output("fwd_ans_dm", ans_dm, 16'd12);
    nop(1'b0, 5'd3);
    check_output("fwd_ans_wb", ans_wb, 16'd12);
    apply_stimulus(OP_PASS, 5'd3, 5'd0, 16'h0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
    check_output("rf3_written", ans_ex, 16'd12);

    // Producer R1+0x100=0x105, consumer fwd+R2 = 0x10C at distances 1/2/3.
    apply_stimulus(OP_ADD, 5'd1, 5'd0, 16'h0100, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
    apply_stimulus(OP_ADD, 5'd0, 5'd2, 16'h0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
    check_output("depth1_sel01", ans_ex, 16'h010C);
    apply_stimulus(OP_ADD, 5'd1, 5'd0, 16'h0100, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
    nop(1'b0, 5'd0);
    apply_stimulus(OP_ADD, 5'd0, 5'd2, 16'h0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
    check_output("depth2_sel10", ans_ex, 16'h010C);
    apply_stimulus(OP_ADD, 5'd1, 5'd0, 16'h0100, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
    nop(1'b0, 5'd0);
    nop(1'b0, 5'd0);
    apply_stimulus(OP_ADD, 5'd0, 5'd2, 16'h0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
    check_output("depth3_sel11", ans_ex, 16'h010C);
    apply_stimulus(OP_ADD, 5'd1, 5'd0, 16'h0100, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
    apply_stimulus(OP_ADD, 5'd4, 5'd2, 16'h0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
    check_output("depth1_sel00_stale", ans_ex, 16'd7);

    // Operand B via forwarding select (imm_sel=0, mux_sel_B=01).
    apply_stimulus(OP_ADD, 5'd2, 5'd0, 16'h0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 5'd0);
    check_output("fwd_b_sel01", ans_ex, 16'd14);

    // Store 0xBEEF at 0x10, load it back.
    apply_stimulus(OP_ADD, 5'd0, 5'd0, 16'h0010, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
    apply_stimulus(OP_ST, 5'd0, 5'd0, 16'hBEEF, 1'b1, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 5'd0);
    check_output("store_pass_a", ans_ex, 16'h0010);
    apply_stimulus(OP_LD, 5'd0, 5'd0, 16'h0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 5'd0);
    nop(1'b1, 5'd0);
    check_output("load_ans_dm", ans_dm, 16'hBEEF);
    nop(1'b1, 5'd0);
    check_output("load_reg_hold", ans_dm, 16'hBEEF);

    // Flags.
    apply_stimulus(OP_ADD, 5'd0, 5'd0, 16'hFFFF, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
    check_output("add_ffff", ans_ex, 16'hFFFF);
    apply_stimulus(OP_ADD, 5'd0, 5'd0, 16'h0001, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
    check_output("add_wrap_res", ans_ex, 16'h0000);
    check_output("add_wrap_z", {15'd0, flag_z}, 16'd1);
    check_output("add_wrap_c", {15'd0, flag_c}, 16'd1);
    apply_stimulus(OP_AND, 5'd1, 5'd0, 16'h00FF, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
    check_output("and_res", ans_ex, 16'h0005);
    check_output("and_c_hold", {15'd0, flag_c}, 16'd1);
    check_output("and_z", {15'd0, flag_z}, 16'd0);
    apply_stimulus(OP_ADD, 5'd0, 5'd0, 16'h0003, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
    check_output("add3_c_clear", {15'd0, flag_c}, 16'd0);
    apply_stimulus(OP_SUB, 5'd0, 5'd0, 16'h0005, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
    check_output("sub_3_5", ans_ex, 16'hFFFE);
    check_output("sub_borrow", {15'd0, flag_c}, 16'd1);
    apply_stimulus(OP_SUB, 5'd2, 5'd0, 16'h0005, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
    check_output("sub_7_5", ans_ex, 16'h0002);
    check_output("sub_no_borrow", {15'd0, flag_c}, 16'd0);

    // Remaining ALU ops with R1=5, R2=7.
    apply_stimulus(OP_XOR, 5'd1, 5'd2, 16'h0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
    check_output("xor", ans_ex, 16'h0002);
    apply_stimulus(OP_OR, 5'd1, 5'd2, 16'h0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
    check_output("or", ans_ex, 16'h0007);
    apply_stimulus(OP_NOT, 5'd1, 5'd2, 16'h0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
    check_output("not", ans_ex, 16'hFFFA);
    apply_stimulus(OP_ADD8, 5'd1, 5'd2, 16'h0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
    check_output("add_bit3_set", ans_ex, 16'd12);
    apply_stimulus(OP_MISC, 5'd1, 5'd2, 16'h0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
    check_output("other_pass_a", ans_ex, 16'd5);
    apply_stimulus(OP_ADD, 5'd0, 5'd0, 16'h8003, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
    apply_stimulus(OP_SHR, 5'd0, 5'd0, 16'h0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
    check_output("shr", ans_ex, 16'h4001);
    apply_stimulus(OP_SHL, 5'd0, 5'd0, 16'h0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
    check_output("shl_trunc", ans_ex, 16'h0006);

    // Immediate add, R0 write discard, same-cycle read-before-write.
    apply_stimulus(OP_ADD, 5'd0, 5'd0, 16'h0002, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
    apply_stimulus(OP_ADD, 5'd0, 5'd0, 16'h0040, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
    check_output("imm_add", ans_ex, 16'h0042);
    nop(1'b0, 5'd0);
    apply_stimulus(OP_PASS, 5'd6, 5'd0, 16'h0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd6);
    check_output("rf_old_value", ans_ex, 16'h0000);
    apply_stimulus(OP_PASS, 5'd6, 5'd0, 16'h0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
    check_output("rf6_written", ans_ex, 16'h0042);
    apply_stimulus(OP_PASS, 5'd0, 5'd0, 16'h0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
    check_output("r0_reads_zero", ans_ex, 16'h0000);

    // Reset with a load in flight.
    apply_stimulus(OP_ADD, 5'd0, 5'd0, 16'h0010, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
    apply_stimulus(OP_ADD, 5'd0, 5'd0, 16'hFFF0, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
    apply_stimulus(OP_LD, 5'd0, 5'd0, 16'h0, 1'b0, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 5'd0);
    check_output("pre_rst_ans_ex", ans_ex, 16'h0010);
    check_output("pre_rst_c", {15'd0, flag_c}, 16'd1);
    reset = 1'b0;
    #1;
    check_output("mid_rst_ans_ex", ans_ex, 16'h0);
    check_output("mid_rst_ans_dm", ans_dm, 16'h0);
    check_output("mid_rst_ans_wb", ans_wb, 16'h0);
    check_output("mid_rst_flags", {14'd0, flag_z, flag_c}, 16'h0);
    apply_stimulus(OP_PASS, 5'd1, 5'd0, 16'h0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 5'd5);
    reset = 1'b1;
    apply_stimulus(OP_PASS, 5'd5, 5'd0, 16'h0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 5'd5);
    check_output("post_rst_r5", ans_ex, 16'h0);
    check_output("post_rst_ld_clear", ans_dm, 16'h0);
    apply_stimulus(OP_PASS, 5'd1, 5'd0, 16'h0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
    check_output("post_rst_r1", ans_ex, 16'h0);
    apply_stimulus(OP_PASS, 5'd5, 5'd0, 16'h0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
    check_output("post_rst_r5_again", ans_ex, 16'h0);

    // Memory keeps its contents across reset.
    apply_stimulus(OP_ADD, 5'd0, 5'd0, 16'h0010, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
    apply_stimulus(OP_LD, 5'd0, 5'd0, 16'h0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 5'd0);
    nop(1'b1, 5'd0);
    check_output("mem_survives_rst", ans_dm, 16'hBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
